// File: rtl/train_sequencer.sv
// train_sequencer: autonomous training/evaluation controller for one
// associate neuron. Stores a small labelled sample set, runs a programmable
// number of training epochs over it through the neuron's forward/backward
// valid/ready streams, then one evaluation pass that counts mismatches.
module train_sequencer #(
   parameter int unsigned ARG_DEPTH   = 2,
   parameter int unsigned ARG_WIDTH   = 8,
   parameter int unsigned RES_WIDTH   = 16,
   parameter int unsigned ERR_WIDTH   = 16,
   parameter int unsigned FBK_DEPTH   = 2,
   parameter int unsigned FBK_WIDTH   = 16,
   parameter int unsigned SAMPLES     = 4,
   parameter int unsigned EPOCH_WIDTH = 8,
   parameter logic [RES_WIDTH-1:0] ACT_HIGH = 'h00ff
) (
   input  logic                             clk,
   input  logic                             rst_n,
   // sample load port (IDLE only)
   input  logic                             wr_en,
   input  logic [$clog2(SAMPLES)-1:0]       wr_addr,
   input  logic [ARG_DEPTH*ARG_WIDTH-1:0]   wr_arg,
   input  logic [RES_WIDTH-1:0]             wr_tgt,
   // run control / status
   input  logic                             start,
   input  logic [EPOCH_WIDTH-1:0]           epochs,
   output logic                             busy,
   output logic                             done,
   output logic [$clog2(SAMPLES+1)-1:0]     miss,
   output logic                             en,
   // forward argument stream
   output logic                             arg_valid,
   input  logic                             arg_ready,
   output logic [ARG_DEPTH*ARG_WIDTH-1:0]   arg_data,
   // forward result stream
   input  logic                             res_valid,
   output logic                             res_ready,
   input  logic [RES_WIDTH-1:0]             res_data,
   // backward error stream
   output logic                             err_valid,
   input  logic                             err_ready,
   output logic [ERR_WIDTH-1:0]             err_data,
   // backward feedback stream (payload discarded)
   input  logic                             fbk_valid,
   output logic                             fbk_ready,
   input  logic [FBK_DEPTH*FBK_WIDTH-1:0]   fbk_data
);

   localparam int unsigned IDX_W  = $clog2(SAMPLES);
   localparam int unsigned MISS_W = $clog2(SAMPLES + 1);
   localparam int unsigned ARG_W  = ARG_DEPTH * ARG_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FWD,
      S_RES,
      S_BWD,
      S_FBK,
      S_NEXT,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [EPOCH_WIDTH-1:0]  epoch_q, epoch_d;
   logic [EPOCH_WIDTH-1:0]  epochs_q, epochs_d;
   logic                    en_q, en_d;
   logic [MISS_W-1:0]       miss_q, miss_d;
   logic [ARG_W-1:0]        arg_data_q, arg_data_d;
   logic [ERR_WIDTH-1:0]    err_data_q, err_data_d;

   logic [ARG_W-1:0]        mem_arg_q [SAMPLES];
   logic [RES_WIDTH-1:0]    mem_tgt_q [SAMPLES];

   logic                    start_ok;
   logic                    wr_ok;
   logic                    res_xfer;
   logic                    last_sample;
   logic [IDX_W-1:0]        idx_inc;
   logic [EPOCH_WIDTH-1:0]  epoch_inc;
   logic [RES_WIDTH-1:0]    act;
   logic [RES_WIDTH-1:0]    diff;
   logic [ERR_WIDTH-1:0]    err_calc;

   // Feedback payload is consumed only to complete the handshake.
   logic unused_fbk;
   assign unused_fbk = ^fbk_data;

   assign start_ok    = (state_q == S_IDLE) && start;
   assign wr_ok       = (state_q == S_IDLE) && wr_en;
   assign res_xfer    = (state_q == S_RES) && res_valid;
   assign last_sample = (idx_q == IDX_W'(SAMPLES - 1));
   assign idx_inc     = idx_q + IDX_W'(1);
   // epoch_q never exceeds epochs_q-1 while training, so +1 cannot wrap.
   assign epoch_inc   = epoch_q + EPOCH_WIDTH'(1);

   // Threshold activation and error, evaluated against the current sample.
   always_comb begin
      act      = res_data[RES_WIDTH-1] ? '0 : ACT_HIGH;
      diff     = mem_tgt_q[idx_q] - act;
      err_calc = ERR_WIDTH'($signed(diff));
   end

   // Sample memory: written only while idle.
   // NOTE: storage arrays carry no reset; every entry is written before use.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_arg_q[wr_addr] <= wr_arg;
         mem_tgt_q[wr_addr] <= wr_tgt;
      end
   end

   // FSM state register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   // NOTE: each always_comb assigns a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start)     state_d = S_FWD;
         S_FWD:  if (arg_ready) state_d = S_RES;
         S_RES:  if (res_valid) state_d = en_q ? S_BWD : S_NEXT;
         S_BWD:  if (err_ready) state_d = S_FBK;
         S_FBK:  if (fbk_valid) state_d = S_NEXT;
         S_NEXT: state_d = (last_sample && !en_q) ? S_DONE : S_FWD;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: handshakes and status decoded from the current state.
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      arg_valid = (state_q == S_FWD);
      res_ready = (state_q == S_RES);
      err_valid = (state_q == S_BWD);
      fbk_ready = (state_q == S_FBK);
   end

   // Datapath next values: run setup, error capture, sample/epoch stepping.
   always_comb begin
      idx_d      = idx_q;
      epoch_d    = epoch_q;
      epochs_d   = epochs_q;
      en_d       = en_q;
      miss_d     = miss_q;
      arg_data_d = arg_data_q;
      err_data_d = err_data_q;

      if (start_ok) begin
         idx_d    = '0;
         epoch_d  = '0;
         epochs_d = epochs;
         miss_d   = '0;
         en_d     = (epochs != '0);
         // A write to entry 0 in the start cycle lands at the same edge,
         // so forward it to the first argument.
         arg_data_d = (wr_en && (wr_addr == '0)) ? wr_arg : mem_arg_q[0];
      end

      if (res_xfer) begin
         err_data_d = err_calc;
         if (!en_q && (err_calc != '0) && (miss_q != MISS_W'(SAMPLES)))
            miss_d = miss_q + MISS_W'(1);
      end

      if (state_q == S_NEXT) begin
         if (!last_sample) begin
            idx_d      = idx_inc;
            arg_data_d = mem_arg_q[idx_inc];
         end else if (en_q) begin
            idx_d      = '0;
            epoch_d    = epoch_inc;
            arg_data_d = mem_arg_q[0];
            if (epoch_inc == epochs_q) en_d = 1'b0;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         epoch_q    <= '0;
         epochs_q   <= '0;
         en_q       <= 1'b0;
         miss_q     <= '0;
         arg_data_q <= '0;
         err_data_q <= '0;
      end else begin
         idx_q      <= idx_d;
         epoch_q    <= epoch_d;
         epochs_q   <= epochs_d;
         en_q       <= en_d;
         miss_q     <= miss_d;
         arg_data_q <= arg_data_d;
         err_data_q <= err_data_d;
      end
   end

   assign en       = en_q;
   assign miss     = miss_q;
   assign arg_data = arg_data_q;
   assign err_data = err_data_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Testbench for train_sequencer: a behavioural neuron peer with optional
// random stalls, and a scoreboard of expected argument/error transfers and
// miss count derived from the sample set, epoch count and neuron function.
module tb_train_sequencer;

   localparam int SAMPLES = 4;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [15:0] wr_arg;
   logic [15:0] wr_tgt;
   logic        start;
   logic [7:0]  epochs;
   logic        busy, done, en;
   logic [2:0]  miss;
   logic        arg_valid, arg_ready;
   logic [15:0] arg_data;
   logic        res_valid, res_ready;
   logic [15:0] res_data;
   logic        err_valid, err_ready;
   logic [15:0] err_data;
   logic        fbk_valid, fbk_ready;
   logic [31:0] fbk_data;

   train_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_arg(wr_arg), .wr_tgt(wr_tgt),
      .start(start), .epochs(epochs), .busy(busy), .done(done), .miss(miss), .en(en),
      .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
      .fbk_valid(fbk_valid), .fbk_ready(fbk_ready), .fbk_data(fbk_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] arg [4];
      logic [15:0] tgt [4];
      int          mode;      // 0 AND-oracle, 1 always -1, 2 byte sum, 3 fixed
      logic [15:0] rfix;
      int          ep;
      bit          stall;
      bit          ovl;       // write entry 0 in the start cycle
      bit          load;
      int          exp_miss;  // -1: model only
      int          exp_err;   // -1: model only
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // peer / scoreboard state
   int          nmode = 0;
   logic [15:0] res_fixed = '0;
   bit          stall_en = 0;
   bit          hold_err = 0;
   logic [15:0] exp_arg_q [$];
   logic [15:0] exp_err_q [$];
   int          n_arg = 0, n_err = 0, done_cnt = 0, stab_viol = 0;
   bit          en_seen = 0;
   logic [15:0] last_err = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] neuron_res(input int mode, input logic [15:0] a);
      case (mode)
         0:       return (a == 16'hffff) ? 16'h0001 : 16'hffff;
         1:       return 16'hffff;
         2:       return 16'($signed(a[7:0])) + 16'($signed(a[15:8]));
         default: return res_fixed;
      endcase
   endfunction

   function automatic logic [15:0] ref_err(input logic [15:0] tgt, input logic [15:0] res);
      logic [15:0] act;
      act = ($signed(res) < 0) ? 16'h0000 : 16'h00ff;
      return tgt - act;
   endfunction

   function automatic bit rnd();
      return !stall_en || ($urandom_range(0, 1) == 1);
   endfunction

   // Behavioural neuron peer and transfer monitor.
   initial begin
      bit          have_res = 0, fbk_pend = 0, arg_stall = 0, err_stall = 0;
      logic [15:0] res_val = '0, arg_prev = '0, err_prev = '0;
      arg_ready = 0; res_valid = 0; err_ready = 0; fbk_valid = 0;
      res_data = '0; fbk_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            have_res = 0; fbk_pend = 0; arg_stall = 0; err_stall = 0;
            arg_ready = 0; res_valid = 0; err_ready = 0; fbk_valid = 0;
         end else begin
            arg_ready = rnd();
            res_valid = have_res && rnd();
            res_data  = res_val;
            err_ready = !hold_err && rnd();
            fbk_valid = fbk_pend && rnd();
            fbk_data  = $urandom();
            #1;
            if (done) done_cnt++;
            if (en) en_seen = 1;
            if (arg_stall && (!arg_valid || arg_data !== arg_prev)) stab_viol++;
            if (err_stall && (!err_valid || err_data !== err_prev)) stab_viol++;
            arg_stall = arg_valid && !arg_ready;
            err_stall = err_valid && !err_ready;
            arg_prev  = arg_data;
            err_prev  = err_data;
            if (arg_valid && arg_ready) begin
               n_arg++;
               if (exp_arg_q.size() > 0) check("arg_data", arg_data, exp_arg_q.pop_front());
               res_val  = neuron_res(nmode, arg_data);
               have_res = 1;
            end
            if (res_valid && res_ready) have_res = 0;
            if (err_valid && err_ready) begin
               n_err++;
               last_err = err_data;
               if (exp_err_q.size() > 0) check("err_data", err_data, exp_err_q.pop_front());
               fbk_pend = 1;
            end
            if (fbk_valid && fbk_ready) fbk_pend = 0;
         end
      end
   end

   function automatic vec_t mk(input logic [63:0] args, input logic [63:0] tgts, input int mode,
                               input int ep, input bit stall, input bit ovl, input int em, input int ee);
      vec_t v;
      for (int s = 0; s < 4; s++) begin
         v.arg[s] = args[16*s +: 16];
         v.tgt[s] = tgts[16*s +: 16];
      end
      v.mode = mode; v.rfix = '0; v.ep = ep; v.stall = stall; v.ovl = ovl;
      v.load = 1; v.exp_miss = em; v.exp_err = ee;
      return v;
   endfunction

   task automatic load(input vec_t v, input bit skip0);
      for (int s = 0; s < 4; s++) begin
         if (!(skip0 && s == 0)) begin
            @(negedge clk);
            wr_en = 1; wr_addr = 2'(s); wr_arg = v.arg[s]; wr_tgt = v.tgt[s];
         end
      end
      @(negedge clk);
      wr_en = 0;
   endtask

   task automatic run_vec(input vec_t v, input bit inject);
      int m_exp = 0;
      int d0;
      int bound;
      exp_arg_q.delete();
      exp_err_q.delete();
      nmode = v.mode; res_fixed = v.rfix; stall_en = v.stall;
      for (int p = 0; p <= v.ep; p++) begin
         for (int s = 0; s < 4; s++) begin
            logic [15:0] e;
            e = ref_err(v.tgt[s], neuron_res(v.mode, v.arg[s]));
            exp_arg_q.push_back(v.arg[s]);
            if (p < v.ep) exp_err_q.push_back(e);
            else if (e != 0 && m_exp < SAMPLES) m_exp++;
         end
      end
      if (v.load) load(v, v.ovl);
      n_arg = 0; n_err = 0; stab_viol = 0; en_seen = 0; d0 = done_cnt;
      @(negedge clk);
      start = 1; epochs = 8'(v.ep);
      if (v.ovl) begin
         wr_en = 1; wr_addr = 0; wr_arg = v.arg[0]; wr_tgt = v.tgt[0];
      end
      @(negedge clk);
      start = 0; wr_en = 0; epochs = 8'hff;
      bound = 100 + (v.ep + 1) * SAMPLES * 40;
      for (int c = 0; c < bound && done_cnt == d0; c++) begin
         @(negedge clk);
         #2;
         if (inject && c == 6) begin
            start = 1; wr_en = 1; wr_addr = 0; wr_arg = 16'h1234; wr_tgt = 16'h5555;
         end else if (inject && c == 7) begin
            start = 0; wr_en = 0;
         end
      end
      check("done_seen", done_cnt - d0, 1);
      repeat (3) @(negedge clk);
      #2;
      check("done_single", done_cnt - d0, 1);
      check("busy_after", busy, 0);
      check("miss", miss, m_exp);
      check("n_arg", n_arg, (v.ep + 1) * 4);
      check("n_err", n_err, v.ep * 4);
      check("stable", stab_viol, 0);
      check("queues_empty", exp_arg_q.size() + exp_err_q.size(), 0);
      if (v.ep == 0) check("en_never", en_seen, 0);
      if (v.exp_miss >= 0) check("miss_table", miss, v.exp_miss);
      if (v.exp_err >= 0) check("err_table", n_err, v.exp_err);
   endtask

   localparam logic [63:0] ARGS_STD = 64'hffff_ff00_00ff_0000;
   localparam logic [63:0] TGT_AND  = 64'h00ff_0000_0000_0000;
   localparam logic [63:0] TGT_OR   = 64'h00ff_00ff_00ff_0000;

   initial begin
      vec_t vecs [5];
      vec_t v;
      int   d0;

      vecs[0] = mk(ARGS_STD, TGT_AND, 0, 25, 0, 0, 0, 100);
      vecs[1] = mk(ARGS_STD, 64'h00ff_00ff_00ff_00ff, 1, 0, 0, 1, 4, 0);
      vecs[2] = mk(ARGS_STD, TGT_OR, 2, 3, 0, 0, 4, 12);
      vecs[3] = mk(ARGS_STD, TGT_OR, 2, 3, 1, 0, 4, 12);
      vecs[4] = mk(ARGS_STD, TGT_OR, 0, 1, 1, 1, 2, 4);

      wr_en = 0; wr_addr = 0; wr_arg = 0; wr_tgt = 0; start = 0; epochs = 0;
      rst_n = 1;
      #1 rst_n = 0;
      #2;
      check("rst_ctrl", {busy, done, en, arg_valid, res_ready, err_valid, fbk_ready}, 0);
      check("rst_data", {miss, arg_data, err_data}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      #2;
      check("idle_ctrl", {busy, done, en, arg_valid, res_ready, err_valid, fbk_ready}, 0);

      // table-driven runs
      for (int i = 0; i < 5; i++) run_vec(vecs[i], 0);

      // start/wr_en while busy, then confirm memory intact on the next run
      v = mk(ARGS_STD, TGT_OR, 2, 2, 1, 0, 4, 8);
      run_vec(v, 1);
      v.load = 0;
      run_vec(v, 0);

      // activation/error corners
      v = mk(ARGS_STD, 64'h00ff_00ff_00ff_00ff, 3, 1, 0, 0, 4, 4);
      v.rfix = 16'h8000;
      run_vec(v, 0);
      check("err_8000", last_err, 16'h00ff);
      v = mk(ARGS_STD, 64'h0, 3, 1, 0, 0, 4, 4);
      v.rfix = 16'h0000;
      run_vec(v, 0);
      check("err_ff01", last_err, 16'hff01);

      // reset while waiting in BWD
      v = mk(ARGS_STD, TGT_OR, 2, 2, 0, 0, 4, 8);
      load(v, 0);
      exp_arg_q.delete(); exp_err_q.delete();
      nmode = 2; stall_en = 0; hold_err = 1;
      @(negedge clk);
      start = 1; epochs = 8'd2;
      @(negedge clk);
      start = 0;
      for (int c = 0; c < 50 && !err_valid; c++) begin
         @(negedge clk);
         #2;
      end
      check("reached_bwd", err_valid, 1);
      check("bwd_err", err_data, 16'hff01);
      #1 rst_n = 0;
      #1;
      check("abort_ctrl", {busy, done, en, arg_valid, res_ready, err_valid, fbk_ready}, 0);
      check("abort_data", {miss, arg_data, err_data}, 0);
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      rst_n = 1; hold_err = 0;
      v.load = 0;
      run_vec(v, 0);

      // randomized runs checked against the model
      for (int r = 0; r < 6; r++) begin
         logic [63:0] a, t;
         a = {$urandom(), $urandom()};
         t = '0;
         for (int s = 0; s < 4; s++) begin
            case ($urandom_range(0, 2))
               0:       t[16*s +: 16] = 16'h0000;
               1:       t[16*s +: 16] = 16'h00ff;
               default: t[16*s +: 16] = 16'($urandom());
            endcase
         end
         v = mk(a, t, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, -1);
         run_vec(v, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
